led_status_scheduler: RTL and testbench
=======================================

// Module: led_status_scheduler
// PURPOSE
//   Shares one LED_Flasher instance between NUM_REQ status requesters.
//   Picks the highest-priority active requester and loads that requester's blink period into the flasher.
//   Keeps the chosen indication visible for at least MIN_HOLD cycles, then re-arbitrates.
//   Sits between status sources (boot, fault, activity, heartbeat) and the flasher's clock/reset/counter/led_state inputs.
// PARAMETERS
//   NUM_REQ        4              number of requesters; index 0 = highest priority
//   MIN_HOLD       32'd50_000_000 minimum cycles an indication is shown before pre-emption/release
//   DEFAULT_PERIOD 32'd25_000_000 period substituted when a requester supplies 0
// PORTS
//   clock           in  1          system clock; all logic on posedge
//   reset           in  1          synchronous, active-high reset
//   req             in  NUM_REQ    level request per requester
//   req_period      in  32*NUM_REQ packed periods; requester i at [32*i+31:32*i]
//   grant           out NUM_REQ    one-hot current owner; 0 when idle
//   active_id       out $clog2(NUM_REQ) index of owner; 0 when idle
//   busy            out 1          1 in LOAD/HOLD
//   flash_counter   out 32         to LED_Flasher counter
//   flash_led_state out 1          to LED_Flasher led_state
//   flash_reset     out 1          to LED_Flasher reset (ORed with system reset at top level)
// BEHAVIOUR
//   - All outputs registered.
//   - Reset values: grant=0, active_id=0, busy=0, flash_counter=DEFAULT_PERIOD, flash_led_state=0, flash_reset=1.
//   - FSM states: IDLE, LOAD, HOLD. Reset -> IDLE from any state; reset mid-HOLD drops grant on the next edge.
//   - IDLE
//     - flash_reset=1, flash_led_state=0 (LED dark), grant=0.
//     - If any req=1 at edge t: winner=lowest set index; go to LOAD at t+1.
//   - LOAD (exactly 1 cycle)
//     - grant/active_id=winner, busy=1, flash_reset=1, flash_led_state=1.
//     - flash_counter=req_period[winner], or DEFAULT_PERIOD if that field is 0.
//     - hold_cnt=MIN_HOLD. Next state HOLD.
//   - HOLD
//     - flash_reset=0 (flasher runs), flash_led_state=1.
//     - hold_cnt decrements by 1 per cycle, saturating at 0.
//     - While hold_cnt!=0: requests ignored. The owner stays granted even if its req drops (minimum visibility).
//     - When hold_cnt==0, re-arbitrate each cycle:
//       - owner req=1 and no lower index req: stay in HOLD.
//       - a lower index req=1 (pre-empt) or owner req=0 with another req=1: new winner=lowest set index -> LOAD.
//       - owner req=0 and no other req: -> IDLE.
//   - Flasher phase on grant:
//     - The flasher restarts from dark on every LOAD, so the first lit phase begins period+1 cycles after HOLD entry.
//   - req_period changes are latched only in LOAD. Changes during HOLD are ignored until the next LOAD.
//   - MIN_HOLD=0: hold_cnt is already 0 on HOLD entry, so re-arbitration is possible on the first HOLD cycle.
//   - Arbitration latency: req edge in IDLE -> grant 1 cycle later -> flasher released 2 cycles later.
//   - Simultaneous reqs: lowest index wins deterministically; no round-robin.
//   - grant is always one-hot or zero; never two bits set.
// TESTING
//   1. Reset held 3 cycles with req=4'b1111
//      -> grant=0, flash_reset=1, flash_counter=DEFAULT_PERIOD throughout.
//   2. MIN_HOLD=10; req=4'b0100 with period 5 at t
//      -> t+1 LOAD: grant=4'b0100, flash_counter=5;
//      -> t+2 flash_reset=0; the flasher then toggles every 6 cycles.
//   3. MIN_HOLD=10; owner 2 holding, req[0] rises 3 cycles into HOLD
//      -> no change until hold_cnt=0, then LOAD with grant=4'b0001 and counter=req_period[0].
//   4. MIN_HOLD=10; owner req drops 1 cycle into HOLD with no other req
//      -> grant persists 10 cycles, then IDLE with flash_reset=1, grant=0.
//   5. req=4'b1000 with period 0
//      -> flash_counter=DEFAULT_PERIOD.
//   6. Reset asserted mid-HOLD
//      -> IDLE next edge; a held req re-grants 1 cycle after reset deasserts.

Source files
------------

// File: rtl/led_status_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : led_status_scheduler
// Purpose  : Shares one LED flasher between NUM_REQ status requesters.
//            Selects the highest-priority active requester (index 0 is the
//            highest), loads its blink period into the flasher, and keeps
//            that indication visible for at least MIN_HOLD cycles before
//            re-arbitrating.
// Ports    : clock           - system clock, all logic on posedge
//            reset           - synchronous, active-high reset
//            req             - level request per requester
//            req_period      - packed 32-bit periods, requester i at [32*i +: 32]
//            grant           - one-hot current owner, 0 when idle
//            active_id       - index of current owner, 0 when idle
//            busy            - high while loading or holding an indication
//            flash_counter   - period handed to the flasher
//            flash_led_state - flasher led_state input (1 = indication shown)
//            flash_reset     - flasher reset (1 = flasher held dark)
// Revision : 1.0 - initial release
// ============================================================================
module led_status_scheduler #(
    parameter int          NUM_REQ        = 4,
    parameter logic [31:0] MIN_HOLD       = 32'd50_000_000,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd25_000_000,
    localparam int         ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [32*NUM_REQ-1:0] req_period,
    output logic [NUM_REQ-1:0]   grant,
    output logic [ID_W-1:0]      active_id,
    output logic                 busy,
    output logic [31:0]          flash_counter,
    output logic                 flash_led_state,
    output logic                 flash_reset
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;

    logic [1:0]         r_state;
    logic [31:0]        r_hold_cnt;
    logic [NUM_REQ-1:0] r_grant;
    logic [ID_W-1:0]    r_active_id;
    logic               r_busy;
    logic [31:0]        r_flash_counter;
    logic               r_flash_led_state;
    logic               r_flash_reset;

    logic [31:0]        w_period [NUM_REQ];
    logic [ID_W-1:0]    w_winner;
    logic [31:0]        w_winner_period;
    logic               w_any_req;
    logic               w_hold_done;
    logic               w_start_load;
    logic               w_to_idle;

    // Unpack the per-requester period fields.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_period
            assign w_period[gi] = req_period[32*gi +: 32];
        end
    endgenerate

    // Fixed-priority encoder: scanning downward leaves the lowest set index.
    always_comb begin
        w_winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_winner = ID_W'(i);
            end
        end
    end

    assign w_any_req       = |req;
    assign w_winner_period = (w_period[w_winner] == 32'd0) ? DEFAULT_PERIOD
                                                           : w_period[w_winner];
    assign w_hold_done     = (r_state == c_ST_HOLD) && (r_hold_cnt == 32'd0);

    // A new load happens from IDLE on any request, or once the hold time has
    // expired and the winner differs from the owner (pre-emption or the owner
    // dropped while someone else is waiting). If the owner is still the
    // winner it simply keeps the flasher.
    assign w_start_load = ((r_state == c_ST_IDLE) && w_any_req) ||
                          (w_hold_done && w_any_req && (w_winner != r_active_id));
    assign w_to_idle    = w_hold_done && !w_any_req;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state           <= c_ST_IDLE;
            r_hold_cnt        <= 32'd0;
            r_grant           <= '0;
            r_active_id       <= '0;
            r_busy            <= 1'b0;
            r_flash_counter   <= DEFAULT_PERIOD;
            r_flash_led_state <= 1'b0;
            r_flash_reset     <= 1'b1;
        end else if (w_start_load) begin
            // Period is latched only here; later edits wait for the next load.
            // The flasher is held in reset for this cycle so it restarts dark.
            r_state           <= c_ST_LOAD;
            r_hold_cnt        <= MIN_HOLD;
            r_grant           <= NUM_REQ'(1) << w_winner;
            r_active_id       <= w_winner;
            r_busy            <= 1'b1;
            r_flash_counter   <= w_winner_period;
            r_flash_led_state <= 1'b1;
            r_flash_reset     <= 1'b1;
        end else begin
            case (r_state)
                c_ST_LOAD: begin
                    r_state       <= c_ST_HOLD;
                    r_flash_reset <= 1'b0;
                end
                c_ST_HOLD: begin
                    if (w_to_idle) begin
                        r_state           <= c_ST_IDLE;
                        r_grant           <= '0;
                        r_active_id       <= '0;
                        r_busy            <= 1'b0;
                        r_flash_led_state <= 1'b0;
                        r_flash_reset     <= 1'b1;
                    end else if (r_hold_cnt != 32'd0) begin
                        r_hold_cnt <= r_hold_cnt - 32'd1;
                    end
                end
                c_ST_IDLE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state           <= c_ST_IDLE;
                    r_grant           <= '0;
                    r_active_id       <= '0;
                    r_busy            <= 1'b0;
                    r_flash_led_state <= 1'b0;
                    r_flash_reset     <= 1'b1;
                end
            endcase
        end
    end

    assign grant           = r_grant;
    assign active_id       = r_active_id;
    assign busy            = r_busy;
    assign flash_counter   = r_flash_counter;
    assign flash_led_state = r_flash_led_state;
    assign flash_reset     = r_flash_reset;

endmodule
`default_nettype wire

// File: tb/tb_led_status_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_status_scheduler
// Purpose  : Self-checking bench for led_status_scheduler (MIN_HOLD = 10,
//            DEFAULT_PERIOD = 77). Expected output snapshots are queued as
//            stimulus is applied and compared after each clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_status_scheduler;

    localparam logic [31:0] c_DEF = 32'd77;

    logic         clock;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] req_period;
    logic [3:0]   grant;
    logic [1:0]   active_id;
    logic         busy;
    logic [31:0]  flash_counter;
    logic         flash_led_state;
    logic         flash_reset;

    int n_tests = 0;
    int n_fail  = 0;
    logic [40:0] sb [$];

    led_status_scheduler #(
        .NUM_REQ        (4),
        .MIN_HOLD       (32'd10),
        .DEFAULT_PERIOD (c_DEF)
    ) u_dut (
        .clock           (clock),
        .reset           (reset),
        .req             (req),
        .req_period      (req_period),
        .grant           (grant),
        .active_id       (active_id),
        .busy            (busy),
        .flash_counter   (flash_counter),
        .flash_led_state (flash_led_state),
        .flash_reset     (flash_reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Snapshot layout: {grant, active_id, busy, flash_counter, led_state, flash_reset}
    function automatic logic [40:0] idle_v(input logic [31:0] cnt);
        return {4'b0000, 2'd0, 1'b0, cnt, 1'b0, 1'b1};
    endfunction

    function automatic logic [40:0] load_v(input logic [1:0] id, input logic [31:0] cnt);
        return {4'b0001 << id, id, 1'b1, cnt, 1'b1, 1'b1};
    endfunction

    function automatic logic [40:0] hold_v(input logic [1:0] id, input logic [31:0] cnt);
        return {4'b0001 << id, id, 1'b1, cnt, 1'b1, 1'b0};
    endfunction

    function automatic logic [40:0] obs();
        return {grant, active_id, busy, flash_counter, flash_led_state, flash_reset};
    endfunction

    task automatic set_period(input int i, input logic [31:0] v);
        req_period[32*i +: 32] = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = 4'b0000;
        req_period = '0;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [40:0] e, o;
        reset = 1'b1;
        req = 4'b1111;
        req_period = '0;
        for (int c = 1; c <= 3; c++) begin
            sb.push_back(idle_v(c_DEF));
            @(posedge clock); #1;
            o = obs(); e = sb.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset c=%0d got=%h exp=%h", c, o, e);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [40:0] e, o;
        do_reset();
        set_period(2, 32'd5);
        req = 4'b0100;
        for (int c = 1; c <= 16; c++) begin
            if (c == 5)  set_period(2, 32'd9);
            if (c == 16) req = 4'b0000;
            sb.push_back((c == 1) ? load_v(2, 5) : (c == 16) ? idle_v(5) : hold_v(2, 5));
            @(posedge clock); #1;
            o = obs(); e = sb.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL basic c=%0d got=%h exp=%h", c, o, e);
            end
        end
    endtask

    task automatic test_preempt();
        logic [40:0] e, o;
        do_reset();
        set_period(2, 32'd5);
        set_period(0, 32'd3);
        req = 4'b0100;
        for (int c = 1; c <= 14; c++) begin
            if (c == 4) req = 4'b0101;
            sb.push_back((c == 1)  ? load_v(2, 5) :
                         (c <= 12) ? hold_v(2, 5) :
                         (c == 13) ? load_v(0, 3) : hold_v(0, 3));
            @(posedge clock); #1;
            o = obs(); e = sb.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL preempt c=%0d got=%h exp=%h", c, o, e);
            end
        end
    endtask

    task automatic test_release();
        logic [40:0] e, o;
        do_reset();
        set_period(2, 32'd5);
        req = 4'b0100;
        for (int c = 1; c <= 14; c++) begin
            if (c == 3) req = 4'b0000;
            sb.push_back((c == 1) ? load_v(2, 5) : (c <= 12) ? hold_v(2, 5) : idle_v(5));
            @(posedge clock); #1;
            o = obs(); e = sb.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL release c=%0d got=%h exp=%h", c, o, e);
            end
        end
    endtask

    // Runs straight after test_release so the counter starts at 5, not 77.
    task automatic test_default_period();
        logic [40:0] e, o;
        set_period(3, 32'd0);
        req = 4'b1000;
        for (int c = 1; c <= 2; c++) begin
            sb.push_back((c == 1) ? load_v(3, c_DEF) : hold_v(3, c_DEF));
            @(posedge clock); #1;
            o = obs(); e = sb.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL default_period c=%0d got=%h exp=%h", c, o, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [40:0] e, o;
        do_reset();
        set_period(1, 32'd4);
        set_period(2, 32'd5);
        req = 4'b0110;
        for (int c = 1; c <= 2; c++) begin
            sb.push_back((c == 1) ? load_v(1, 4) : hold_v(1, 4));
            @(posedge clock); #1;
            o = obs(); e = sb.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL simultaneous c=%0d got=%h exp=%h", c, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [40:0] e, o;
        do_reset();
        set_period(1, 32'd4);
        set_period(3, 32'd6);
        req = 4'b0010;
        for (int c = 1; c <= 14; c++) begin
            if (c == 2) req = 4'b1000;
            sb.push_back((c == 1)  ? load_v(1, 4) :
                         (c <= 12) ? hold_v(1, 4) :
                         (c == 13) ? load_v(3, 6) : hold_v(3, 6));
            @(posedge clock); #1;
            o = obs(); e = sb.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL back_to_back c=%0d got=%h exp=%h", c, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [40:0] e, o;
        do_reset();
        set_period(2, 32'd5);
        req = 4'b0100;
        for (int c = 1; c <= 6; c++) begin
            if (c == 4) reset = 1'b1;
            if (c == 5) reset = 1'b0;
            sb.push_back((c == 1 || c == 5) ? load_v(2, 5) :
                         (c == 4)           ? idle_v(c_DEF) : hold_v(2, 5));
            @(posedge clock); #1;
            o = obs(); e = sb.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_mid_hold c=%0d got=%h exp=%h", c, o, e);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req = 4'b0000;
        req_period = '0;
        test_reset();
        test_basic();
        test_preempt();
        test_release();
        test_default_period();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
